// File: rtl/alu_pkg.sv
// alu_pkg: shared types and decode helpers for the digit-serial ALU.
//   alu_cmd_e   - 3-bit operation code carried on the command port
//   alu_state_e - control FSM states
//   needs_invert() - operations that feed ~b into the adder (SUB, SLT)
//   is_arith()     - operations whose carry/overflow flags are meaningful
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_XOR  = 3'd2,
    ALU_SLT  = 3'd3,
    ALU_AND  = 3'd4,
    ALU_NAND = 3'd5,
    ALU_NOR  = 3'd6,
    ALU_OR   = 3'd7
  } alu_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  function automatic logic needs_invert(alu_cmd_e cmd);
    return (cmd == ALU_SUB) || (cmd == ALU_SLT);
  endfunction

  function automatic logic is_arith(alu_cmd_e cmd);
    return (cmd == ALU_ADD) || (cmd == ALU_SUB) || (cmd == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_chunk.sv
// alu_chunk: combinational CHUNK-bit ALU slice, reused every cycle by the
// serial top.
//   a, b     - operand chunks (b raw; inverted internally for the adder)
//   cin      - carry into this chunk
//   invert   - feed ~b to the adder (SUB/SLT)
//   command  - operation select
//   res      - chunk result (sum for arithmetic ops, bitwise op otherwise)
//   cout     - carry out of the chunk adder
//   sum_msb  - top bit of the chunk sum (sign bit on the last chunk)
module alu_chunk
  import alu_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  input  logic             invert,
  input  alu_cmd_e         command,
  output logic [CHUNK-1:0] res,
  output logic             cout,
  output logic             sum_msb
);

  logic [CHUNK-1:0] bx;
  logic [CHUNK:0]   sum;

  always_comb begin
    bx      = b ^ {CHUNK{invert}};
    sum     = {1'b0, a} + {1'b0, bx} + {{CHUNK{1'b0}}, cin};
    cout    = sum[CHUNK];
    sum_msb = sum[CHUNK-1];
    res     = sum[CHUNK-1:0];
    // Bitwise operations deliberately use the raw b, not the adder input.
    case (command)
      ALU_XOR:  res = a ^ b;
      ALU_AND:  res = a & b;
      ALU_NAND: res = ~(a & b);
      ALU_NOR:  res = ~(a | b);
      ALU_OR:   res = a | b;
      default:  res = sum[CHUNK-1:0];
    endcase
  end

endmodule

// File: rtl/alu_serial.sv
// alu_serial: digit-serial WIDTH-bit ALU, CHUNK bits per cycle, LSB chunk first.
//   clk, reset          - clock, asynchronous active-high reset
//   in_valid/in_ready   - request handshake (in_ready only in IDLE)
//   command, a, b       - operation and two's-complement operands, sampled on accept
//   out_valid/out_ready - result handshake (out_valid only in DONE)
//   result              - operation result (SLT: 0 or 1)
//   carryout, overflow  - final adder carry / signed overflow (0 for logic ops)
//   zero                - result == 0
// Result and flags only change on the final RUN edge and on reset.
module alu_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       command,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK) + 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  function automatic logic signed_ovf(logic a_msb, logic bx_msb, logic s_msb);
    return (a_msb == bx_msb) && (s_msb != a_msb);
  endfunction

  alu_state_e state_q, state_d;
  logic       accept;

  logic [CW-1:0]           cnt_q;
  logic                    carry_q;
  logic                    nz_q;
  alu_cmd_e                cmd_q;
  logic signed [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0]        wrk_q;

  logic             last, inv, arith, ovf, slt_bit, zero_fin;
  logic [CHUNK-1:0] a_k, b_k, ch_res;
  logic             ch_cout, ch_msb;
  logic [WIDTH-1:0] res_full, res_fin;

  // Control FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign last   = (cnt_q == LAST);

  // Chunk slice and final-result assembly
  always_comb begin
    inv   = needs_invert(cmd_q);
    arith = is_arith(cmd_q);
    a_k   = a_q[int'(cnt_q)*CHUNK +: CHUNK];
    b_k   = b_q[int'(cnt_q)*CHUNK +: CHUNK];
  end

  alu_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a       (a_k),
    .b       (b_k),
    .cin     (carry_q),
    .invert  (inv),
    .command (cmd_q),
    .res     (ch_res),
    .cout    (ch_cout),
    .sum_msb (ch_msb)
  );

  always_comb begin
    // ch_msb is the sign bit only on the last chunk; ovf is consumed only then.
    ovf      = signed_ovf(a_q[WIDTH-1], b_q[WIDTH-1] ^ inv, ch_msb);
    slt_bit  = ch_msb ^ ovf;
    res_full = wrk_q;
    res_full[int'(cnt_q)*CHUNK +: CHUNK] = ch_res;
    if (cmd_q == ALU_SLT) begin
      res_fin  = {{(WIDTH-1){1'b0}}, slt_bit};
      zero_fin = ~slt_bit;
    end else begin
      res_fin  = res_full;
      zero_fin = ~(nz_q | (|ch_res));
    end
  end

  // Operand and working registers: data only, not reset
  always_ff @(posedge clk) begin
    if (accept) begin
      cmd_q <= alu_cmd_e'(command);
      a_q   <= a;
      b_q   <= b;
    end
    if (state_q == ST_RUN) wrk_q[int'(cnt_q)*CHUNK +: CHUNK] <= ch_res;
  end

  // Counter, carry/nonzero state and visible outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      nz_q     <= 1'b0;
      result   <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (accept) begin
      cnt_q   <= '0;
      carry_q <= needs_invert(alu_cmd_e'(command));
      nz_q    <= 1'b0;
    end else if (state_q == ST_RUN) begin
      carry_q <= ch_cout;
      nz_q    <= nz_q | (|ch_res);
      if (last) begin
        cnt_q    <= '0;
        result   <= res_fin;
        carryout <= arith & ch_cout;
        overflow <= arith & ovf;
        zero     <= zero_fin;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule
